// File: rtl/sr_cnt_pkg.sv
// Shared types and helpers for the clocked-SR counter drive logic.
// Holds the FSM state encoding, the fault counter width and the wrap-aware next-count function.
package sr_cnt_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } sr_state_e;

    localparam int FAULT_CNT_W = 8;

    // Step a mod-modulus count by one in either direction, wrapping at the ends.
    function automatic logic [31:0] next_count(input logic [31:0] cnt,
                                               input logic        up,
                                               input int unsigned modulus);
        logic [31:0] res;
        if (up) begin
            res = (cnt == modulus - 1) ? 32'd0 : cnt + 32'd1;
        end else begin
            res = (cnt == 32'd0) ? modulus - 1 : cnt - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sr_excite_cell.sv
// One-bit S/R excitation: moves an SR flop from cur to nxt on the coming edge.
// Purely combinational; never asserts S and R together.
module sr_excite_cell (
    input  logic cur_i,
    input  logic nxt_i,
    output logic s_o,
    output logic r_o
);

    assign s_o = ~cur_i & nxt_i;
    assign r_o = cur_i & ~nxt_i;

endmodule

// File: rtl/sr_excitation_counter.sv
// Shadow mod-MODULUS up/down counter driving an external SR flop bank; S/R are combinational,
// so bank and shadow count move on the same edge. No backpressure: a request is taken every cycle.
module sr_excitation_counter
    import sr_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    input  logic [WIDTH-1:0]       q_fb,
    output logic [WIDTH-1:0]       S,
    output logic [WIDTH-1:0]       R,
    output logic [WIDTH-1:0]       count,
    output logic                   tc,
    output logic                   fault,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    sr_state_e              state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [FAULT_CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] s_raw, r_raw;
    logic             mismatch;
    logic             wrap;

    assign mismatch = (state_q == RUN) && (q_fb != count_q);
    assign wrap     = en && (up ? (count_q == CNT_MAX) : (count_q == '0));

    always_comb begin
        nxt = count_q;
        if (load) begin
            nxt = (32'(load_val) < MODULUS) ? load_val : '0;
        end else if (en) begin
            nxt = WIDTH'(next_count(32'(count_q), up, MODULUS));
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_excite_cell u_cell (
            .cur_i (count_q[i]),
            .nxt_i (nxt[i]),
            .s_o   (s_raw[i]),
            .r_o   (r_raw[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        fault_cnt_d = fault_cnt_q;
        S           = '0;
        R           = '0;
        tc          = 1'b0;
        fault       = 1'b0;
        unique case (state_q)
            CLR: begin
                // The bank has no reset of its own; hold every R high until RUN.
                R       = '1;
                count_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (mismatch) begin
                    fault   = 1'b1;
                    state_d = CLR;
                    if (fault_cnt_q != '1) begin
                        fault_cnt_d = fault_cnt_q + 1'b1;
                    end
                end else begin
                    S       = s_raw;
                    R       = r_raw;
                    count_d = nxt;
                    tc      = ~load & wrap;
                end
            end
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLR;
            count_q     <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign count     = count_q;
    assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_sr_excitation_counter.sv
// Directed and random checks of sr_excitation_counter against a behavioural SR flop bank.
module tb_sr_excitation_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load;
    logic [3:0] load_val;
    logic [3:0] q_fb;
    logic [3:0] S, R, count;
    logic       tc, fault;
    logic [7:0] fault_cnt;

    logic [3:0] bank_q;
    logic [3:0] flip;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Behavioural ClockedSR bank: S sets, R clears, neither holds. No reset.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (S[i])      bank_q[i] <= 1'b1;
            else if (R[i]) bank_q[i] <= 1'b0;
        end
    end

    assign q_fb = bank_q ^ flip;

    sr_excitation_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .q_fb      (q_fb),
        .S         (S),
        .R         (R),
        .count     (count),
        .tc        (tc),
        .fault     (fault),
        .fault_cnt (fault_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] lv);
        en = e; up = u; load = l; load_val = lv;
        #2;
    endtask

    int model;

    initial begin
        rst = 1'b1; flip = 4'h0;
        en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'h0;
        #2;
        chk("rst_S",     32'(S), 32'h0);
        chk("rst_R",     32'(R), 32'hF);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_fcnt",  32'(fault_cnt), 32'h0);
        chk("rst_tc",    32'(tc), 32'h0);
        step(); step();
        rst = 1'b0;
        #2;
        chk("clr_R", 32'(R), 32'hF);
        step();
        chk("run_count", 32'(count), 32'h0);
        chk("run_qfb",   32'(q_fb), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk("run_idle_R", 32'(R), 32'h0);

        // Bring count to 9, then wrap upward.
        drive(1'b0, 1'b0, 1'b1, 4'd9);
        chk("ld9_S", 32'(S), 32'h9);
        step();
        chk("ld9_qfb", 32'(q_fb), 32'h9);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        chk("wrapup_tc", 32'(tc), 32'h1);
        chk("wrapup_S",  32'(S), 32'h0);
        chk("wrapup_R",  32'(R), 32'h9);
        step();
        chk("wrapup_count", 32'(count), 32'h0);
        chk("wrapup_qfb",   32'(q_fb), 32'h0);

        drive(1'b1, 1'b0, 1'b0, 4'h0);
        chk("wrapdn_tc", 32'(tc), 32'h1);
        chk("wrapdn_S",  32'(S), 32'h9);
        chk("wrapdn_R",  32'(R), 32'h0);
        step();
        chk("wrapdn_count", 32'(count), 32'h9);
        chk("wrapdn_qfb",   32'(q_fb), 32'h9);

        drive(1'b1, 1'b1, 1'b0, 4'h0);
        step();
        chk("to0_count", 32'(count), 32'h0);
        drive(1'b1, 1'b1, 1'b1, 4'd7);
        chk("ld7_S",  32'(S), 32'h7);
        chk("ld7_tc", 32'(tc), 32'h0);
        step();
        chk("ld7_count", 32'(count), 32'h7);
        drive(1'b0, 1'b0, 1'b1, 4'd12);
        chk("ld12_R", 32'(R), 32'h7);
        step();
        chk("ld12_count", 32'(count), 32'h0);

        // Feedback fault at count 3.
        drive(1'b0, 1'b0, 1'b1, 4'd3);
        step();
        chk("ld3_count", 32'(count), 32'h3);
        flip = 4'h1;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        chk("flt_fault", 32'(fault), 32'h1);
        chk("flt_S",     32'(S), 32'h0);
        chk("flt_R",     32'(R), 32'h0);
        chk("flt_tc",    32'(tc), 32'h0);
        step();
        flip = 4'h0;
        #2;
        chk("flt_fcnt",   32'(fault_cnt), 32'h1);
        chk("flt_clr_R",  32'(R), 32'hF);
        chk("flt_clr_S",  32'(S), 32'h0);
        chk("flt_clr_f",  32'(fault), 32'h0);
        step();
        chk("rec_count", 32'(count), 32'h0);
        chk("rec_qfb",   32'(q_fb), 32'h0);
        #2;
        chk("rec_fault", 32'(fault), 32'h0);
        chk("rec_fcnt",  32'(fault_cnt), 32'h1);

        model = 0;
        for (int c = 0; c < 1000; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            chk("rnd_SR",    32'(S & R), 32'h0);
            chk("rnd_fault", 32'(fault), 32'h0);
            if (load)    model = (load_val < 4'd10) ? int'(load_val) : 0;
            else if (en) model = up ? (model + 1) % 10 : (model + 9) % 10;
            step();
            chk("rnd_count", 32'(count), 32'(model));
            chk("rnd_qfb",   32'(q_fb), 32'(model));
        end
        chk("rnd_fcnt", 32'(fault_cnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
